frame_strobe_writer: RTL and testbench

//  Writer side of the tile config-latch interface. Consumes a 32-bit configuration word stream
//  (valid/ready) and drives FrameData plus a one-hot FrameStrobe pulse per frame, so that every

---
 rtl/frame_strobe_writer_pkg.sv | 25 ++
 rtl/frame_onehot_dec.sv | 24 ++
 rtl/frame_strobe_writer.sv | 134 +++++++++++++
 tb/tb_frame_strobe_writer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_strobe_writer_pkg.sv
// Shared definitions for the frame strobe writer: FSM state encoding,
// header word field positions and the default header sync tag.
package frame_strobe_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  // Header word layout: [31:24] tag, [23:16] column, [15:8] first frame, [7:0] count
  localparam int HDR_TAG_LSB   = 24;
  localparam int HDR_COL_LSB   = 16;
  localparam int HDR_FIRST_LSB = 8;
  localparam int HDR_COUNT_LSB = 0;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hFA;

  function automatic logic [7:0] hdr_field(input logic [31:0] word, input int lsb);
    return word[lsb +: 8];
  endfunction

endpackage

// File: rtl/frame_onehot_dec.sv
// Binary index to one-hot decoder with enable and out-of-range flag.
//  idx    in   IDX_W   binary index
//  en     in   1       when low, onehot is all zero
//  onehot out  WIDTH   one-hot of idx when enabled and in range, else zero
//  oor    out  1       idx >= WIDTH (independent of en)
module frame_onehot_dec #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 8
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [WIDTH-1:0] onehot,
  output logic             oor
);

  always_comb begin
    oor    = (32'(idx) >= 32'(WIDTH));
    onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      onehot[i] = en && !oor && (32'(idx) == i);
    end
  end

endmodule

// File: rtl/frame_strobe_writer.sv
// Writer side of the tile config-latch interface. Takes a header word
// (tag, column, first frame, frame count) followed by that many data words
// from a valid/ready stream and, per data word, presents the word on
// FrameData, then pulses one FrameStrobe bit with the column's ColSelect bit.
//  CLK          in   1                clock
//  RST          in   1                synchronous reset, active-high
//  s_data       in   32               stream word
//  s_valid      in   1                word present
//  s_ready      out  1                word accepted when s_valid & s_ready
//  FrameData    out  FrameBitsPerRow  frame row data to fabric
//  FrameStrobe  out  MaxFramesPerCol  one-hot latch enable, only during STROBE
//  ColSelect    out  NoOfCols         one-hot column enable, only during STROBE
//  busy         out  1                high outside IDLE
//  err_sync     out  1                sticky: header tag mismatch
//  err_range    out  1                sticky: column or frame index out of range
//  frames_done  out  16               frames strobed, saturating
module frame_strobe_writer
  import frame_strobe_writer_pkg::*;
#(
  parameter int         MaxFramesPerCol = 32,
  parameter int         FrameBitsPerRow = 32,  // must equal the 32-bit stream width
  parameter int         NoOfCols        = 16,
  parameter int         StrobeCycles    = 1,   // 1..15
  parameter logic [7:0] SyncByte        = DEFAULT_SYNC_BYTE
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [31:0]                s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [NoOfCols-1:0]        ColSelect,
  output logic                       busy,
  output logic                       err_sync,
  output logic                       err_range,
  output logic [15:0]                frames_done
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t     state, state_nxt;
  logic [7:0] col, frame_idx, remaining;
  logic [3:0] scnt;
  logic       accept, in_strobe, col_oor, frame_oor;
  logic [7:0] hdr_tag, hdr_col, hdr_first, hdr_count;

  assign hdr_tag   = hdr_field(s_data, HDR_TAG_LSB);
  assign hdr_col   = hdr_field(s_data, HDR_COL_LSB);
  assign hdr_first = hdr_field(s_data, HDR_FIRST_LSB);
  assign hdr_count = hdr_field(s_data, HDR_COUNT_LSB);

  // Ready is forced low while RST is high so nothing is accepted in the reset cycle.
  assign s_ready   = !RST && ((state == ST_IDLE) || (state == ST_DATA));
  assign accept    = s_valid && s_ready;
  assign busy      = (state != ST_IDLE);
  assign in_strobe = (state == ST_STROBE);

  // An out-of-range column turns the burst into a drain: words are consumed
  // with the normal timing, but neither decoder is ever enabled.
  frame_onehot_dec #(.WIDTH(NoOfCols), .IDX_W(8)) u_col_dec (
    .idx    (col),
    .en     (in_strobe),
    .onehot (ColSelect),
    .oor    (col_oor)
  );

  frame_onehot_dec #(.WIDTH(MaxFramesPerCol), .IDX_W(8)) u_frame_dec (
    .idx    (frame_idx),
    .en     (in_strobe && !col_oor),
    .onehot (FrameStrobe),
    .oor    (frame_oor)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept && (hdr_tag == SyncByte) && (hdr_count != 8'd0)) state_nxt = ST_DATA;
      ST_DATA:   if (accept) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_STROBE;
      ST_STROBE: if (scnt == 4'(StrobeCycles - 1)) state_nxt = ST_HOLD;
      ST_HOLD:   state_nxt = (remaining == 8'd1) ? ST_IDLE : ST_DATA;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      FrameData   <= '0;
      col         <= '0;
      frame_idx   <= '0;
      remaining   <= '0;
      scnt        <= '0;
      err_sync    <= 1'b0;
      err_range   <= 1'b0;
      frames_done <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (hdr_tag != SyncByte) begin
              err_sync <= 1'b1;
            end else if (hdr_count != 8'd0) begin
              col       <= hdr_col;
              frame_idx <= hdr_first;
              remaining <= hdr_count;
            end
          end
        end
        ST_DATA: begin
          // Column range is judged on the registered column, one cycle after the header.
          if (col_oor) err_range <= 1'b1;
          if (accept) FrameData <= s_data[FrameBitsPerRow-1:0];
          scnt <= '0;
        end
        ST_STROBE: begin
          scnt <= scnt + 4'd1;
          if (!col_oor && frame_oor) err_range <= 1'b1;
        end
        ST_HOLD: begin
          if (!col_oor && !frame_oor) frames_done <= sat_inc16(frames_done);
          frame_idx <= frame_idx + 8'd1;  // wraps 255 -> 0
          remaining <= remaining - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_strobe_writer.sv
// Self-checking bench for frame_strobe_writer: directed header scenarios,
// a mid-burst reset and randomized gapped bursts, scored against a
// word-level model of the expected strobe events and status flags.
module tb_frame_strobe_writer;

  localparam int SC = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] FrameData;
  logic [31:0] FrameStrobe;
  logic [15:0] ColSelect;
  logic        busy, err_sync, err_range;
  logic [15:0] frames_done;

  always #5 CLK = ~CLK;

  frame_strobe_writer #(.StrobeCycles(SC)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .ColSelect   (ColSelect),
    .busy        (busy),
    .err_sync    (err_sync),
    .err_range   (err_range),
    .frames_done (frames_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word-level reference model
  typedef struct packed {
    logic [31:0] fs;
    logic [31:0] cs;
    logic [31:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic       m_in_burst;
  logic [7:0] m_col, m_idx, m_rem;
  logic       m_err_sync, m_err_range;
  int         m_done;

  task automatic model_reset();
    exp_q.delete();
    m_in_burst  = 1'b0;
    m_col       = '0;
    m_idx       = '0;
    m_rem       = '0;
    m_err_sync  = 1'b0;
    m_err_range = 1'b0;
    m_done      = 0;
  endtask

  task automatic model_word(input logic [31:0] w);
    ev_t ev;
    if (!m_in_burst) begin
      if (w[31:24] != 8'hFA) begin
        m_err_sync = 1'b1;
      end else if (w[7:0] != 8'd0) begin
        m_in_burst = 1'b1;
        m_col = w[23:16];
        m_idx = w[15:8];
        m_rem = w[7:0];
        if (m_col >= 8'd16) m_err_range = 1'b1;
      end
    end else begin
      if (m_col < 8'd16) begin
        ev.cs   = 32'h1 << m_col;
        ev.data = w;
        if (m_idx < 8'd32) begin
          ev.fs = 32'h1 << m_idx;
          m_done++;
        end else begin
          ev.fs = '0;
          m_err_range = 1'b1;
        end
        exp_q.push_back(ev);
      end
      m_idx = m_idx + 8'd1;
      m_rem = m_rem - 8'd1;
      if (m_rem == 8'd0) m_in_burst = 1'b0;
    end
  endtask

  // Drive one word after `gap` idle cycles; returns #1 after the accepting edge.
  task automatic send_word(input logic [31:0] w, input int gap);
    int t;
    repeat (gap) begin
      @(posedge CLK); #1;
    end
    s_valid = 1'b1;
    s_data  = w;
    t = 0;
    while (!s_ready && t < 200) begin
      @(posedge CLK); #1;
      t++;
    end
    if (!s_ready) begin
      check("send_tmo", {31'd0, s_ready}, 32'd1);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "stream stalled");
    end
    @(posedge CLK); #1;
    model_word(w);
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic check_status();
    repeat (SC + 4) @(posedge CLK);
    #1;
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("err_sync", {31'd0, err_sync}, {31'd0, m_err_sync});
    check("err_range", {31'd0, err_range}, {31'd0, m_err_range});
    check("frames_done", {16'd0, frames_done}, (m_done > 65535) ? 32'hFFFF : 32'(m_done));
    check("evq_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input logic exp_ready);
    check("rst_data", FrameData, 0);
    check("rst_fs", FrameStrobe, 0);
    check("rst_cs", {16'd0, ColSelect}, 0);
    check("rst_ready", {31'd0, s_ready}, {31'd0, exp_ready});
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_esync", {31'd0, err_sync}, 0);
    check("rst_erange", {31'd0, err_range}, 0);
    check("rst_done", {16'd0, frames_done}, 0);
  endtask

  // Output monitor: strobe pulse shape, data stability and event order
  logic        in_pulse = 1'b0;
  int          width = 0;
  int          low_run = 0;
  logic [31:0] p_fs, p_cs, p_data;
  logic [31:0] prev_data = '0;

  always @(negedge CLK) begin
    ev_t e;
    if (RST) begin
      in_pulse = 1'b0;
      low_run  = 0;
    end else begin
      check("fs_onehot0", {31'd0, $onehot0(FrameStrobe)}, 1);
      check("cs_onehot0", {31'd0, $onehot0(ColSelect)}, 1);
      if (FrameStrobe != 0 || ColSelect != 0) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          width    = 1;
          p_fs     = FrameStrobe;
          p_cs     = {16'd0, ColSelect};
          p_data   = FrameData;
          check("setup_data", FrameData, prev_data);
        end else begin
          width++;
          check("strobe_fs", FrameStrobe, p_fs);
          check("strobe_cs", {16'd0, ColSelect}, p_cs);
          check("strobe_data", FrameData, p_data);
        end
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        check("strobe_w", width, SC);
        check("hold_data", FrameData, p_data);
        if (exp_q.size() == 0) begin
          check("ev_unexpected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("ev_fs", p_fs, e.fs);
          check("ev_cs", p_cs, e.cs);
          check("ev_data", p_data, e.data);
        end
      end
      if (!s_ready) begin
        low_run++;
      end else begin
        if (low_run != 0) check("ready_low", low_run, SC + 2);
        low_run = 0;
      end
      prev_data = FrameData;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tag, col, first, cnt;
    model_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_values(1'b0);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("ready_idle", {31'd0, s_ready}, 1);

    // Two frames in column 3 starting at frame 5
    send_word(32'hFA030502, 0);
    send_word(32'hAAAA0001, 0);
    send_word(32'hBBBB0002, 0);
    check_status();

    // Bad tag, then a good single-frame header
    send_word(32'h11000001, 0);
    check_status();
    send_word(32'hFA000001, 1);
    send_word(32'hCCCC0003, 0);
    check_status();

    // Frame 31 in range, frame 32 out of range
    send_word(32'hFA001F02, 0);
    send_word(32'h31313131, 0);
    send_word(32'h32323232, 2);
    check_status();

    // Column 16 out of range: word drained
    send_word(32'hFA100001, 0);
    send_word(32'hDEADBEEF, 0);
    check_status();

    // Frame index wrap 254, 255, 0
    send_word(32'hFA01FE03, 0);
    send_word(32'h000000FE, 0);
    send_word(32'h000000FF, 1);
    send_word(32'h00000100, 0);
    check_status();

    // Reset during STROBE of a 3-frame burst
    send_word(32'hFA020103, 0);
    send_word(32'h0D0D0D0D, 0);
    @(posedge CLK); #1;
    check("pre_rst_fs", FrameStrobe, 32'h2);
    check("pre_rst_cs", {16'd0, ColSelect}, 32'h4);
    check("pre_rst_busy", {31'd0, busy}, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    check_reset_values(1'b0);
    RST = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    check_reset_values(1'b1);

    // Randomized gapped bursts
    for (int b = 0; b < 25; b++) begin
      tag   = ($urandom_range(0, 9) == 0) ? 8'h5A : 8'hFA;
      col   = 8'($urandom_range(0, 17));
      first = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 36));
      cnt   = 8'($urandom_range(0, 4));
      send_word({tag, col, first, cnt}, $urandom_range(0, 3));
      while (m_in_burst) send_word($urandom, $urandom_range(0, 3));
    end
    check_status();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
